camera_stream_packer: RTL

//  Capture-side stage feeding the 17-bit camera FIFO (FIFO_cam) that the VideoController frame uploader drains.

---
 rtl/camera_stream_packer_pkg.sv | 25 ++
 rtl/camera_stream_packer_sync_edge.sv | 58 +++++
 rtl/camera_stream_packer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/camera_stream_packer_pkg.sv
// Shared types for the camera capture path.
//   cam_word_t         : one 17-bit FIFO_cam word (bit16 = frame-start flag)
//   FRAME_START_MARKER : word written once per frame ahead of its pixels
//   packer_state_t     : capture FSM states
//   pack_pixel         : orders the two captured bytes into an RGB565 word
package CameraStreamTypes;

  typedef logic [16:0] cam_word_t;

  localparam cam_word_t FRAME_START_MARKER = 17'h10000;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    BLANK
  } packer_state_t;

  function automatic cam_word_t pack_pixel(input logic [7:0] first_byte,
                                           input logic [7:0] second_byte,
                                           input bit         hi_byte_first);
    if (hi_byte_first) return {1'b0, first_byte, second_byte};
    else               return {1'b0, second_byte, first_byte};
  endfunction

endpackage

// File: rtl/camera_stream_packer_sync_edge.sv
// cam_sync_edge: registers the raw camera inputs once and detects edges on
// VSYNC (normalised so "active" always means vertical blanking) and HREF.
// Ports:
//   clk, reset_n          : pixel clock, async active-low reset
//   cam_vsync/href/data   : raw camera inputs
//   vs_rise / vs_fall     : blanking starts (frame end) / blanking ends (frame start)
//   href_p1               : registered HREF
//   href_fall             : HREF just went low (line end)
//   data_p1               : registered data byte, aligned with href_p1
module cam_sync_edge #(
  parameter bit VSYNC_ACT_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       href_p1,
  output logic       href_fall,
  output logic [7:0] data_p1
);

  logic vsync_p1;
  logic vsync_p2;
  logic href_p2;
  logic vs_act_p1;
  logic vs_act_p2;

  // Stage p1: input capture; stage p2: previous value for edge detection.
  // VSYNC resets to its inactive level so that coming out of reset during
  // active video cannot be mistaken for a frame start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_p1 <= ~VSYNC_ACT_HIGH;
      vsync_p2 <= ~VSYNC_ACT_HIGH;
      href_p1  <= 1'b0;
      href_p2  <= 1'b0;
    end else begin
      vsync_p1 <= cam_vsync;
      vsync_p2 <= vsync_p1;
      href_p1  <= cam_href;
      href_p2  <= href_p1;
    end
  end

  always_ff @(posedge clk) begin
    data_p1 <= cam_data;
  end

  assign vs_act_p1 = vsync_p1 ^ ~VSYNC_ACT_HIGH;
  assign vs_act_p2 = vsync_p2 ^ ~VSYNC_ACT_HIGH;
  assign vs_rise   = vs_act_p1 & ~vs_act_p2;
  assign vs_fall   = ~vs_act_p1 & vs_act_p2;
  assign href_fall = ~href_p1 & href_p2;

endmodule

// File: rtl/camera_stream_packer.sv
// camera_stream_packer: turns the OV7670 RGB565 byte stream into 17-bit
// FIFO_cam words (frame-start marker + one word per pixel), checks frame
// geometry and reports FIFO overflow.
// Ports:
//   clk, reset_n       : camera PCLK, async active-low reset
//   cam_vsync/href/data: camera parallel interface
//   fifo_full          : FIFO_cam Full
//   fifo_data/wr_en    : FIFO_cam write port, one word per wr_en pulse
//   frame_done         : 1-cycle pulse, frame closed clean
//   frame_error        : sticky geometry error, cleared at frame start
//   overflow           : sticky word drop, cleared at frame start
//   frame_count        : frames started since reset (wraps)
module camera_stream_packer
  import CameraStreamTypes::*;
#(
  parameter int FRAME_WIDTH    = 640,
  parameter int FRAME_HEIGHT   = 480,
  parameter bit VSYNC_ACT_HIGH = 1'b1,
  parameter bit HI_BYTE_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  input  logic        fifo_full,
  output logic [16:0] fifo_data,
  output logic        fifo_wr_en,
  output logic        frame_done,
  output logic        frame_error,
  output logic        overflow,
  output logic [15:0] frame_count
);

  localparam logic [10:0] PIX_TGT  = 11'(FRAME_WIDTH);
  localparam logic [9:0]  LINE_TGT = 10'(FRAME_HEIGHT);

  function automatic logic [10:0] sat_inc_pix(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] sat_inc_line(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  logic          vs_rise;
  logic          vs_fall;
  logic          href_p1;
  logic          href_fall;
  logic [7:0]    data_p1;

  packer_state_t state;
  logic          phase;
  logic [10:0]   pix_cnt;
  logic [9:0]    line_cnt;
  logic [7:0]    first_byte_p2;
  cam_word_t     pix_p2;
  logic          vld_p2;
  logic          marker_pend;

  logic [9:0]    line_cnt_nxt;
  logic          line_err;
  logic          frame_err_nxt;
  logic          wr_marker;
  logic          wr_pix;
  logic          pix_drop;

  cam_sync_edge #(
    .VSYNC_ACT_HIGH(VSYNC_ACT_HIGH)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .cam_vsync(cam_vsync),
    .cam_href (cam_href),
    .cam_data (cam_data),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .href_p1  (href_p1),
    .href_fall(href_fall),
    .data_p1  (data_p1)
  );

  // A line end may coincide with the frame end, so the frame-end line check
  // uses the already-incremented line count and this cycle's line verdict.
  always_comb begin
    line_cnt_nxt = line_cnt;
    line_err     = 1'b0;
    if (state == ACTIVE && href_fall) begin
      line_cnt_nxt = sat_inc_line(line_cnt);
      line_err     = phase | (pix_cnt != PIX_TGT);
    end
    frame_err_nxt = frame_error | line_err | (line_cnt_nxt != LINE_TGT);

    // Marker owns the write port while pending; any pixel meeting it (or a
    // full FIFO) is lost.
    wr_marker = marker_pend & ~fifo_full;
    pix_drop  = vld_p2 & (marker_pend | fifo_full);
    wr_pix    = vld_p2 & ~marker_pend & ~fifo_full;
  end

  // Stage p2: capture FSM, byte pairing, geometry counters.
  // A frame start seen mid-ACTIVE is always preceded by the frame-end edge,
  // which has already flagged the short frame before this restart clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      phase       <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      vld_p2      <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      vld_p2     <= 1'b0;
      if (vs_fall) begin
        state       <= ACTIVE;
        phase       <= 1'b0;
        pix_cnt     <= '0;
        line_cnt    <= '0;
        frame_error <= 1'b0;
        frame_count <= frame_count + 16'd1;
      end else begin
        case (state)
          ACTIVE: begin
            if (href_p1) begin
              phase <= ~phase;
              if (phase) begin
                vld_p2  <= 1'b1;
                pix_cnt <= sat_inc_pix(pix_cnt);
              end
            end
            if (href_fall) begin
              phase    <= 1'b0;
              pix_cnt  <= '0;
              line_cnt <= line_cnt_nxt;
              if (line_err) frame_error <= 1'b1;
            end
            if (vs_rise) begin
              frame_error <= frame_err_nxt;
              frame_done  <= ~frame_err_nxt & ~overflow & ~pix_drop;
              state       <= BLANK;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == ACTIVE && !vs_fall && href_p1) begin
      if (!phase) first_byte_p2 <= data_p1;
      else        pix_p2        <= pack_pixel(first_byte_p2, data_p1, HI_BYTE_FIRST);
    end
  end

  // Stage p3: FIFO write arbitration.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_wr_en  <= 1'b0;
      fifo_data   <= '0;
      marker_pend <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      fifo_wr_en <= wr_marker | wr_pix;
      if (wr_marker)   fifo_data <= FRAME_START_MARKER;
      else if (wr_pix) fifo_data <= pix_p2;

      if (vs_fall)        marker_pend <= 1'b1;
      else if (wr_marker) marker_pend <= 1'b0;

      if (vs_fall)       overflow <= 1'b0;
      else if (pix_drop) overflow <= 1'b1;
    end
  end

endmodule
